// File: rtl/mem_arb.sv
// Two-master (IFU/LSU) to one-slave memory port arbiter.
// One outstanding transaction, round-robin on contention.
module mem_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_valid_i,
  output logic              m0_ready_o,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_valid_i,
  output logic              m1_ready_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_wen_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic [MASK_W-1:0] m1_mask_i,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,
  output logic              s_valid_o,
  input  logic              s_ready_i,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic              s_wen_o,
  output logic [DATA_W-1:0] s_wdata_o,
  output logic [MASK_W-1:0] s_mask_o,
  input  logic              s_rvalid_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic              s_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic              er0_q, er0_d;
  logic              er1_q, er1_d;
  logic              gnt0, gnt1;

  // Grant: sole requester wins, a tie goes to the master that did not win last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_i && state_q == IDLE) begin
      if (m0_valid_i && m1_valid_i) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = m0_valid_i;
        gnt1 = m1_valid_i;
      end
    end
  end

  // Next-state and payload/response capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    er0_d   = er0_q;
    er1_d   = er1_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          last_d  = gnt1;
          addr_d  = gnt1 ? m1_addr_i : m0_addr_i;
          wen_d   = gnt1 & m1_wen_i;
          wdata_d = gnt1 ? m1_wdata_i : '0;
          mask_d  = gnt1 ? m1_mask_i : '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (s_ready_i) state_d = RESP;
      end
      RESP: begin
        if (s_rvalid_i) begin
          state_d = IDLE;
          if (owner_q) begin
            rv1_d = 1'b1;
            rd1_d = wen_q ? '0 : s_rdata_i;
            er1_d = s_err_i;
          end else begin
            rv0_d = 1'b1;
            rd0_d = s_rdata_i;
            er0_d = s_err_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      er0_q   <= 1'b0;
      er1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      er0_q   <= er0_d;
      er1_q   <= er1_d;
    end
  end

  assign m0_ready_o  = gnt0;
  assign m1_ready_o  = gnt1;
  assign m0_rvalid_o = rv0_q;
  assign m0_rdata_o  = rd0_q;
  assign m0_err_o    = er0_q;
  assign m1_rvalid_o = rv1_q;
  assign m1_rdata_o  = rd1_q;
  assign m1_err_o    = er1_q;
  assign s_valid_o   = (state_q == REQ);
  assign s_addr_o    = addr_q;
  assign s_wen_o     = wen_q;
  assign s_wdata_o   = wdata_q;
  assign s_mask_o    = mask_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb.
// Inputs change on negedge; outputs are checked 1ns later.
module tb_mem_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_valid_i;
  logic        m0_ready_o;
  logic [31:0] m0_addr_i;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m0_err_o;
  logic        m1_valid_i;
  logic        m1_ready_o;
  logic [31:0] m1_addr_i;
  logic        m1_wen_i;
  logic [31:0] m1_wdata_i;
  logic [7:0]  m1_mask_i;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  logic        m1_err_o;
  logic        s_valid_o;
  logic        s_ready_i;
  logic [31:0] s_addr_o;
  logic        s_wen_o;
  logic [31:0] s_wdata_o;
  logic [7:0]  s_mask_o;
  logic        s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic        s_err_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mem_arb #(.ADDR_W(32), .DATA_W(32), .MASK_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m0_valid_i  (m0_valid_i),
    .m0_ready_o  (m0_ready_o),
    .m0_addr_i   (m0_addr_i),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m0_err_o    (m0_err_o),
    .m1_valid_i  (m1_valid_i),
    .m1_ready_o  (m1_ready_o),
    .m1_addr_i   (m1_addr_i),
    .m1_wen_i    (m1_wen_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_mask_i   (m1_mask_i),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o),
    .m1_err_o    (m1_err_o),
    .s_valid_o   (s_valid_o),
    .s_ready_i   (s_ready_i),
    .s_addr_o    (s_addr_o),
    .s_wen_o     (s_wen_o),
    .s_wdata_o   (s_wdata_o),
    .s_mask_o    (s_mask_o),
    .s_rvalid_i  (s_rvalid_i),
    .s_rdata_i   (s_rdata_i),
    .s_err_i     (s_err_i)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  logic        g;
  logic [31:0] ea;

  initial begin
    rst_i      = 1'b0;
    m0_valid_i = 1'b0;
    m0_addr_i  = '0;
    m1_valid_i = 1'b0;
    m1_addr_i  = '0;
    m1_wen_i   = 1'b0;
    m1_wdata_i = '0;
    m1_mask_i  = '0;
    s_ready_i  = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    s_err_i    = 1'b0;

    // 1: reset for two cycles, then IFU wins the first tie
    repeat (2) @(posedge clk_i);
    nxt(); #1;
    chk1("rst_m0_ready", m0_ready_o, 1'b0);
    chk1("rst_m1_ready", m1_ready_o, 1'b0);
    chk1("rst_s_valid", s_valid_o, 1'b0);
    chk1("rst_m0_rvalid", m0_rvalid_o, 1'b0);
    chk1("rst_m1_rvalid", m1_rvalid_o, 1'b0);
    chk32("rst_s_addr", s_addr_o, 32'h0);
    chk32("rst_m0_rdata", m0_rdata_o, 32'h0);
    rst_i = 1'b1;
    m0_valid_i = 1'b1;
    m1_valid_i = 1'b1;
    #1;
    chk1("tie0_m0_ready", m0_ready_o, 1'b1);
    chk1("tie0_m1_ready", m1_ready_o, 1'b0);
    m0_valid_i = 1'b0;
    m1_valid_i = 1'b0;
    #1;
    chk1("drop_m0_ready", m0_ready_o, 1'b0);

    // 2: single fetch, minimum latency
    nxt();
    m0_valid_i = 1'b1;
    m0_addr_i  = 32'h8000_0000;
    #1;
    chk1("f_m0_ready", m0_ready_o, 1'b1);
    nxt();
    m0_valid_i = 1'b0;
    s_ready_i  = 1'b1;
    #1;
    chk1("f_s_valid", s_valid_o, 1'b1);
    chk32("f_s_addr", s_addr_o, 32'h8000_0000);
    chk1("f_s_wen", s_wen_o, 1'b0);
    chk1("f_m0_ready_req", m0_ready_o, 1'b0);
    nxt();
    s_ready_i  = 1'b0;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h0000_0413;
    #1;
    chk1("f_s_valid_resp", s_valid_o, 1'b0);
    chk1("f_m0_rvalid_early", m0_rvalid_o, 1'b0);
    chk1("f_m1_rvalid_a", m1_rvalid_o, 1'b0);
    nxt();
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    #1;
    chk1("f_m0_rvalid", m0_rvalid_o, 1'b1);
    chk32("f_m0_rdata", m0_rdata_o, 32'h0000_0413);
    chk1("f_m0_err", m0_err_o, 1'b0);
    chk1("f_m1_rvalid_b", m1_rvalid_o, 1'b0);
    nxt(); #1;
    chk1("f_m0_rvalid_pulse", m0_rvalid_o, 1'b0);

    // 5: LSU read returning an error
    m1_valid_i = 1'b1;
    m1_addr_i  = 32'h8000_2000;
    m1_wen_i   = 1'b0;
    #1;
    chk1("e_m1_ready", m1_ready_o, 1'b1);
    chk1("e_m0_ready", m0_ready_o, 1'b0);
    nxt();
    m1_valid_i = 1'b0;
    s_ready_i  = 1'b1;
    #1;
    chk32("e_s_addr", s_addr_o, 32'h8000_2000);
    chk1("e_s_wen", s_wen_o, 1'b0);
    nxt();
    s_ready_i  = 1'b0;
    s_rvalid_i = 1'b1;
    s_err_i    = 1'b1;
    s_rdata_i  = 32'h1234_5678;
    #1;
    chk1("e_m1_err_early", m1_err_o, 1'b0);
    nxt();
    s_rvalid_i = 1'b0;
    s_err_i    = 1'b0;
    s_rdata_i  = '0;
    #1;
    chk1("e_m1_rvalid", m1_rvalid_o, 1'b1);
    chk1("e_m1_err", m1_err_o, 1'b1);
    chk32("e_m1_rdata", m1_rdata_o, 32'h1234_5678);
    chk1("e_m0_rvalid", m0_rvalid_o, 1'b0);
    nxt();

    // 3: contention, four back-to-back grants 0,1,0,1
    m0_valid_i = 1'b1;
    m0_addr_i  = 32'h8000_0100;
    m1_valid_i = 1'b1;
    m1_addr_i  = 32'h8000_0200;
    m1_wen_i   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      g  = (i % 2) == 1;
      ea = g ? 32'h8000_0200 : 32'h8000_0100;
      #1;
      chk1($sformatf("c%0d_m0_ready", i), m0_ready_o, !g);
      chk1($sformatf("c%0d_m1_ready", i), m1_ready_o, g);
      nxt();
      s_ready_i = 1'b1;
      #1;
      chk1($sformatf("c%0d_s_valid", i), s_valid_o, 1'b1);
      chk32($sformatf("c%0d_s_addr", i), s_addr_o, ea);
      nxt();
      s_ready_i  = 1'b0;
      s_rvalid_i = 1'b1;
      s_rdata_i  = 32'h100 + 32'(i);
      nxt();
      s_rvalid_i = 1'b0;
      #1;
      chk1($sformatf("c%0d_m0_rvalid", i), m0_rvalid_o, !g);
      chk1($sformatf("c%0d_m1_rvalid", i), m1_rvalid_o, g);
      if (g)
        chk32($sformatf("c%0d_m1_rdata", i), m1_rdata_o, 32'h100 + 32'(i));
      else
        chk32($sformatf("c%0d_m0_rdata", i), m0_rdata_o, 32'h100 + 32'(i));
    end
    m0_valid_i = 1'b0;
    m1_valid_i = 1'b0;
    nxt();

    // 4: LSU write, slave ready delayed three cycles
    m1_valid_i = 1'b1;
    m1_addr_i  = 32'h8000_1000;
    m1_wen_i   = 1'b1;
    m1_wdata_i = 32'hdead_beef;
    m1_mask_i  = 8'h0f;
    #1;
    chk1("w_m1_ready", m1_ready_o, 1'b1);
    nxt();
    m1_valid_i = 1'b0;
    m1_addr_i  = '0;
    m1_wen_i   = 1'b0;
    m1_wdata_i = '0;
    m1_mask_i  = '0;
    for (int k = 0; k < 4; k++) begin
      s_ready_i = (k == 3);
      #1;
      chk1($sformatf("w%0d_s_valid", k), s_valid_o, 1'b1);
      chk32($sformatf("w%0d_s_addr", k), s_addr_o, 32'h8000_1000);
      chk1($sformatf("w%0d_s_wen", k), s_wen_o, 1'b1);
      chk32($sformatf("w%0d_s_wdata", k), s_wdata_o, 32'hdead_beef);
      chk32($sformatf("w%0d_s_mask", k), 32'(s_mask_o), 32'h0f);
      nxt();
    end
    s_ready_i  = 1'b0;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hffff_ffff;
    #1;
    chk1("w_s_valid_resp", s_valid_o, 1'b0);
    nxt();
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    #1;
    chk1("w_m1_rvalid", m1_rvalid_o, 1'b1);
    chk32("w_m1_rdata", m1_rdata_o, 32'h0);
    chk1("w_m1_err", m1_err_o, 1'b0);
    nxt();

    // 6: reset while waiting for the response, then a stray response
    m0_valid_i = 1'b1;
    m0_addr_i  = 32'h8000_3000;
    #1;
    chk1("r_m0_ready", m0_ready_o, 1'b1);
    nxt();
    m0_valid_i = 1'b0;
    s_ready_i  = 1'b1;
    nxt();
    s_ready_i = 1'b0;
    rst_i     = 1'b0;
    nxt();
    rst_i      = 1'b1;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h5555_5555;
    #1;
    chk1("r_s_valid", s_valid_o, 1'b0);
    chk1("r_m0_rvalid_a", m0_rvalid_o, 1'b0);
    nxt();
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    #1;
    chk1("r_m0_rvalid_b", m0_rvalid_o, 1'b0);
    chk1("r_m1_rvalid_b", m1_rvalid_o, 1'b0);
    chk32("r_m0_rdata", m0_rdata_o, 32'h0);
    m0_valid_i = 1'b1;
    m1_valid_i = 1'b1;
    #1;
    chk1("r_idle_m0_ready", m0_ready_o, 1'b1);
    chk1("r_idle_m1_ready", m1_ready_o, 1'b0);
    m0_valid_i = 1'b0;
    m1_valid_i = 1'b0;
    nxt();
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
